// File: rtl/down_counter_pkg.sv
// down_counter_pkg: shared width default, all-ones helper and count typedef
// for the synchronous down counter and its T flip-flop cells.
package down_counter_pkg;

    localparam int CNT_WIDTH_DEFAULT = 4;

    typedef logic [CNT_WIDTH_DEFAULT-1:0] count_t;

    // Returns a 16-bit vector whose low 'width' bits are ones; callers take
    // the slice they need, since counter widths never exceed 16 bits.
    function automatic logic [15:0] cnt_ones(input int width);
        logic [15:0] r;
        r = '0;
        for (int i = 0; i < 16; i++) begin
            if (i < width) begin
                r[i] = 1'b1;
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/t_ff_sync.sv
// t_ff_sync: synchronous T flip-flop with synchronous reset to RST_VAL and
// a synchronous parallel load. Priority is rst > ld > t.
module t_ff_sync #(
    parameter logic RST_VAL = 1'b1
) (
    input  logic clk,
    input  logic rst,
    input  logic ld,
    input  logic d,
    input  logic t,
    output logic q,
    output logic q_bar
);

    // Reset wins, then the parallel load, then the toggle request.
    always_ff @(posedge clk) begin
        if (rst) begin
            q <= RST_VAL;
        end else if (ld) begin
            q <= d;
        end else if (t) begin
            q <= ~q;
        end
    end

    assign q_bar = ~q;

endmodule

// File: rtl/sync_down_counter_t.sv
// sync_down_counter_t: loadable synchronous down counter built from a chain of
// t_ff_sync cells, with a registered one-cycle borrow pulse on underflow.
// Optional macro DOWN_CNT_RELOAD_EN adds a reload register so that underflow
// reloads the last loaded value instead of wrapping to all ones.
module sync_down_counter_t
    import down_counter_pkg::*;
#(
    parameter int WIDTH = CNT_WIDTH_DEFAULT
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    output logic [WIDTH-1:0] count,
    output logic             zero,
    output logic             borrow
);

    logic [WIDTH-1:0] count_n;
    logic [WIDTH-1:0] toggle;
    logic [WIDTH-1:0] ff_d;
    logic             ff_ld;
    logic             underflow;

    // Every bit below bit i is zero exactly when bit i must flip on a decrement.
    assign toggle[0] = en;
    for (genvar i = 1; i < WIDTH; i++) begin : g_toggle
        assign toggle[i] = en & (count[i-1:0] == '0);
    end

    // zero is decoded from the inverted flop outputs and carries no state.
    assign zero      = &count_n;
    assign underflow = en & ~load & zero;

`ifdef DOWN_CNT_RELOAD_EN
    localparam logic [15:0]      ONES_WIDE = cnt_ones(WIDTH);
    localparam logic [WIDTH-1:0] ONES      = ONES_WIDE[WIDTH-1:0];

    logic [WIDTH-1:0] reload_q;

    // Reload register remembers the most recent load value for periodic reload.
    always_ff @(posedge clk) begin
        if (rst) begin
            reload_q <= ONES;
        end else if (load) begin
            reload_q <= load_val;
        end
    end

    // On underflow the flops load the reload value instead of toggling.
    assign ff_ld = load | underflow;
    assign ff_d  = load ? load_val : reload_q;
`else
    // Toggling every bit from zero already lands on all ones, so the wrap
    // needs no load path; only an explicit load drives the flop load inputs.
    assign ff_ld = load;
    assign ff_d  = load_val;
`endif

    for (genvar i = 0; i < WIDTH; i++) begin : g_bit
        t_ff_sync #(
            .RST_VAL (1'b1)
        ) u_tff (
            .clk   (clk),
            .rst   (rst),
            .ld    (ff_ld),
            .d     (ff_d[i]),
            .t     (toggle[i]),
            .q     (count[i]),
            .q_bar (count_n[i])
        );
    end

    // Borrow is registered so it rises in the cycle after the underflow edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            borrow <= 1'b0;
        end else begin
            borrow <= underflow;
        end
    end

endmodule

// File: tb/tb_sync_down_counter_t.sv
// tb_sync_down_counter_t: scoreboard bench for sync_down_counter_t. Stimulus
// drives inputs on the falling edge and pushes the reference model's expected
// outputs into a queue; a monitor pops and compares after each rising edge.
// Honours DOWN_CNT_RELOAD_EN in its reference model.
module tb_sync_down_counter_t;

    localparam int W    = 4;
    localparam int MAXV = (1 << W) - 1;

    typedef struct {
        int   count;
        logic borrow;
        logic zero;
    } exp_t;

    logic         clk;
    logic         rst;
    logic         en;
    logic         load;
    logic [W-1:0] load_val;
    logic [W-1:0] count;
    logic         zero;
    logic         borrow;

    exp_t exp_q[$];
    int   n_checks;
    int   n_fail;

    // Reference model state, in plain integers.
    int   cnt_m;
    int   reload_m;
    logic borrow_m;

    sync_down_counter_t #(
        .WIDTH (W)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .en       (en),
        .load     (load),
        .load_val (load_val),
        .count    (count),
        .zero     (zero),
        .borrow   (borrow)
    );

    // Free-running clock, period 10.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Drive one cycle of inputs and record what the outputs must be after the edge.
    task automatic applyStimulus(input logic r, input logic ld,
                                 input logic [W-1:0] lv, input logic e);
        exp_t x;
        @(negedge clk);
        rst      = r;
        load     = ld;
        load_val = lv;
        en       = e;
        borrow_m = 1'b0;
        if (r) begin
            cnt_m    = MAXV;
            reload_m = MAXV;
        end else if (ld) begin
            cnt_m    = int'(lv);
            reload_m = int'(lv);
        end else if (e) begin
            if (cnt_m == 0) begin
`ifdef DOWN_CNT_RELOAD_EN
                cnt_m = reload_m;
`else
                cnt_m = MAXV;
`endif
                borrow_m = 1'b1;
            end else begin
                cnt_m = cnt_m - 1;
            end
        end
        x.count  = cnt_m;
        x.borrow = borrow_m;
        x.zero   = (cnt_m == 0);
        exp_q.push_back(x);
    endtask

    // Compare one set of DUT outputs against one scoreboard entry.
    task automatic checkOutput(input exp_t x);
        n_checks++;
        if (int'(count) != x.count) begin
            n_fail++;
            $display("[TB] FAIL count at %0t: actual %0d required %0d", $time, count, x.count);
        end
        n_checks++;
        if (borrow !== x.borrow) begin
            n_fail++;
            $display("[TB] FAIL borrow at %0t: actual %b required %b", $time, borrow, x.borrow);
        end
        n_checks++;
        if (zero !== x.zero) begin
            n_fail++;
            $display("[TB] FAIL zero at %0t: actual %b required %b", $time, zero, x.zero);
        end
    endtask

    // Monitor: after each rising edge, pop a pending expectation and check it.
    initial begin
        exp_t x;
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() > 0) begin
                x = exp_q.pop_front();
                checkOutput(x);
            end
        end
    end

    // Stimulus: directed scenarios first, then randomized traffic.
    initial begin
        n_checks = 0;
        n_fail   = 0;
        cnt_m    = MAXV;
        reload_m = MAXV;
        rst      = 1'b1;
        en       = 1'b0;
        load     = 1'b0;
        load_val = '0;

        $display("[TB] reset");
        repeat (2) applyStimulus(1'b1, 1'b0, 4'h0, 1'b0);

        $display("[TB] free run");
        repeat (17) applyStimulus(1'b0, 1'b0, 4'h0, 1'b1);

        $display("[TB] load priority at zero");
        applyStimulus(1'b0, 1'b1, 4'h0, 1'b0);
        applyStimulus(1'b0, 1'b1, 4'h5, 1'b1);
        repeat (6) applyStimulus(1'b0, 1'b0, 4'h0, 1'b1);

        $display("[TB] hold");
        applyStimulus(1'b0, 1'b1, 4'h9, 1'b0);
        repeat (3) applyStimulus(1'b0, 1'b0, 4'h0, 1'b0);

        $display("[TB] reset mid-count and at underflow");
        applyStimulus(1'b0, 1'b1, 4'h3, 1'b0);
        applyStimulus(1'b1, 1'b0, 4'h0, 1'b1);
        applyStimulus(1'b0, 1'b1, 4'h0, 1'b0);
        applyStimulus(1'b1, 1'b0, 4'h0, 1'b1);
        applyStimulus(1'b0, 1'b0, 4'h0, 1'b0);

        $display("[TB] reload period and zero reload value");
        applyStimulus(1'b0, 1'b1, 4'h3, 1'b0);
        repeat (9) applyStimulus(1'b0, 1'b0, 4'h0, 1'b1);
        applyStimulus(1'b0, 1'b1, 4'h0, 1'b0);
        repeat (4) applyStimulus(1'b0, 1'b0, 4'h0, 1'b1);

        $display("[TB] randomized traffic");
        for (int i = 0; i < 400; i++) begin
            logic         r;
            logic         ld;
            logic         e;
            logic [W-1:0] lv;
            r  = ($urandom_range(0, 49) == 0);
            ld = ($urandom_range(0, 9) == 0);
            e  = ($urandom_range(0, 3) != 0);
            lv = W'($urandom_range(0, MAXV));
            if ($urandom_range(0, 3) == 0) begin
                lv = '0;
            end
            applyStimulus(r, ld, lv, e);
        end

        applyStimulus(1'b0, 1'b0, 4'h0, 1'b0);
        repeat (3) @(posedge clk);
        #2;
        n_checks++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("[TB] FAIL drain: actual %0d pending required 0", exp_q.size());
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/sync_down_counter_t.md
# sync_down_counter_t

Synchronous, loadable, down-counting counter built from a chain of synchronous T flip-flops. It is the counting-down counterpart to the ripple up counter in the sequential counters library. All bits share one clock, so there is no ripple skew. It provides a registered borrow pulse for cascading and timer use, and sits alongside the other counters under 3_Sequential/Counters.

## Interface
Parameters:
- WIDTH, 4, counter width in bits (legal range 2..16).

Ports:
- clk  input  1  single clock; all state updates on posedge clk.
- rst  input  1  reset, synchronous and active-high.
- en  input  1  count enable; decrement by 1 on a clock edge when high.
- load  input  1  synchronous parallel load; overrides en.
- load_val  input  WIDTH  value captured on load.
- count  output  WIDTH  current counter value, registered.
- zero  output  1  combinational flag, count == 0.
- borrow  output  1  registered one-cycle pulse on underflow.

## Operation
- Priority on each posedge clk is rst > load > en > hold.
- **rst = 1:**
  - count <= all ones ({WIDTH{1'b1}}).
  - borrow <= 0.
  - Reload register <= all ones (only when DOWN_CNT_RELOAD_EN is defined).
- **load = 1 (rst = 0):**
  - count <= load_val.
  - borrow <= 0.
  - en is ignored.
  - The reload register also captures load_val (only when DOWN_CNT_RELOAD_EN is defined).
- **en = 1, load = 0, count != 0:**
  - count <= count - 1.
  - borrow <= 0.
- **en = 1, load = 0, count == 0 (underflow):**
  - Without the macro, count <= all ones (modulo-2^WIDTH wrap).
  - With the macro, count <= reload register.
  - borrow <= 1 in both cases.
- **en = 0, load = 0:**
  - count holds.
  - borrow <= 0.
- **T-FF decomposition (mandatory structure):**
  - Bit i toggles when en & (count[i-1:0] == 0).
  - Bit 0 toggles whenever en is high.
  - Load and reset are applied through the flip-flop's synchronous load and reset inputs, not through toggle.
  - The reload path is a synchronous load of the reload value, gated by underflow.
- **zero:** pure decode of count; it carries no state.

## Timing
- Reset value of every output: count = all ones, borrow = 0, zero = 0.
- Latency:
  - en or load to count update: 1 cycle. count changes on the same edge that samples en or load.
  - borrow is asserted during the cycle immediately following the underflow edge. In that cycle count already shows the wrapped or reloaded value.
  - borrow lasts exactly 1 cycle per underflow.
- Continuous en from N:
  - count reaches 0 after N edges.
  - Underflow occurs on edge N+1.
  - The period is 2^WIDTH cycles (non-reload) or reload+1 cycles (reload mode).
- Simultaneous load and en at count == 0: load wins, and no borrow is generated.
- rst asserted mid-count: takes effect on the next edge; any pending borrow is cleared on that edge.
- load_val = 0 followed by en: the next edge is an underflow and borrow pulses.
- Reload mode with reload register = 0: count stays 0 and borrow pulses every enabled cycle.

## Configuration
- Macro: DOWN_CNT_RELOAD_EN.
- **Defined:**
  - Adds a WIDTH-bit reload register, written on load and reset to all ones.
  - Underflow reloads count from this register, giving a programmable-period timer.
- **Undefined:**
  - No reload register exists.
  - Underflow wraps to all ones.
  - Ports and the behaviour of load, en and rst are identical in both builds.

## Structure
- **Package down_counter_pkg:**
  - CNT_WIDTH_DEFAULT = 4.
  - A function cnt_ones(width) returning the all-ones reset value.
  - A typedef for the count vector at the default width.
- **Sub-module t_ff_sync:**
  - Ports: clk, rst, ld, d, t, q, q_bar.
  - Synchronous active-high reset to rst_val, a per-instance parameter (1 for this counter).
  - Priority rst > ld > t. With ld = 1, q <= d; with t = 1, q <= ~q.
  - The top instantiates WIDTH copies via generate.
  - The toggle and borrow logic lives in the top.

## Test plan
- **Reset:** assert rst for 2 cycles -> count = 4'hF, borrow = 0, zero = 0.
- **Free run (no macro):** after reset, hold en = 1 for 17 cycles.
  - count steps F, E, ..., 1, 0, then wraps to F.
  - borrow is high for exactly 1 cycle, the cycle after the 0 -> F edge.
  - zero is high only while count = 0.
- **Load priority:**
  - With count = 0, drive load = 1, load_val = 4'h5, en = 1 -> count = 5 and borrow stays 0.
  - Then en for 5 cycles -> count = 0; the next edge gives borrow.
- **Hold:** with count = 9, drop en for 3 cycles -> count stays 9 and borrow stays 0.
- **Reset mid-count:**
  - With count = 3, assert rst -> the next edge gives count = F.
  - At underflow, assert rst in the same cycle borrow would rise -> borrow is never asserted.
- **Reload (DOWN_CNT_RELOAD_EN):**
  - Load 4'h3, then continuous en -> count sequence 3, 2, 1, 0, 3, 2, ... with borrow every 4 cycles.
  - Load 4'h0, then en -> count stays 0 and borrow is high every cycle.
